// File: rtl/aes_stream_port.sv
// aes_stream_port
//   Byte-stream front end for one iterative AES core (cipher or Inv_cipher).
//   Collects 16 input bytes into a 128-bit block (first byte in [127:120]),
//   resets and then enables the core for LATENCY cycles, captures the result
//   and streams it back out as 16 bytes, most significant byte first.
//
// Ports
//   clk, reset        : single rising-edge clock, synchronous active-high reset
//   in_data/in_valid  : input byte stream (sink side), in_ready back-pressure
//   out_data/out_valid: output byte stream (source side), out_ready from sink
//   core_state        : block presented to the core's state_in
//   core_reset        : core reset, high while idle (LOAD) and in START
//   core_enable       : core enable, high only in RUN
//   core_result       : core output (encrypted/decrypted)
//   busy              : high in any state other than LOAD
module aes_stream_port #(
    parameter int unsigned LATENCY = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] core_state,
    output logic         core_reset,
    output logic         core_enable,
    input  logic [127:0] core_result,
    output logic         busy
);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_UNLOAD = 2'd3;

    localparam logic [7:0] LAT = LATENCY[7:0];

    logic [1:0]   state_q, state_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]   lat_cnt_q, lat_cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_q, out_d;
    logic         busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        blk_d      = blk_q;
        out_d      = out_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    blk_d      = {blk_q[119:0], in_data};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    // counter wrap marks the 16th byte
                    if (byte_cnt_q == 4'd15) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                lat_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // the count reaches LAT after LAT enabled edges; the core
                // output is valid during that cycle and captured at its end
                if (lat_cnt_q == LAT) begin
                    out_d      = core_result;
                    byte_cnt_d = '0;
                    lat_cnt_d  = '0;
                    state_d    = S_UNLOAD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 8'd1;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    out_d      = {out_q[119:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd15) begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        busy_d = (state_d != S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LOAD;
            byte_cnt_q <= '0;
            lat_cnt_q  <= '0;
            blk_q      <= '0;
            out_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            blk_q      <= blk_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready    = (state_q == S_LOAD);
    assign out_valid   = (state_q == S_UNLOAD);
    assign out_data    = out_q[127:120];
    assign core_state  = blk_q;
    assign core_reset  = (state_q == S_LOAD) || (state_q == S_START);
    assign core_enable = (state_q == S_RUN);
    assign busy        = busy_q;

endmodule
